// File: rtl/switch_conditioner_pkg.sv
// rtl/switch_conditioner_pkg.sv - shared switch-input constants for the conditioner and its helpers
package switch_conditioner_pkg;

    localparam int SW_WIDTH    = 4;
    localparam int CLK_HZ      = 50_000_000;
    localparam int DEBOUNCE_MS = 10;

    // Settling window expressed in clock cycles at the board clock rate.
    localparam int DEBOUNCE_CYCLES_DEFAULT = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/switch_conditioner_sync2.sv
// rtl/switch_conditioner_sync2.sv - generic two-flop synchroniser, async active-high reset
module switch_conditioner_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] s1_d, s1_q;
    logic [WIDTH-1:0] s2_d, s2_q;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/switch_conditioner.sv
// rtl/switch_conditioner.sv - synchronise, debounce and hand off slide-switch values
// Optional SWITCH_CONDITIONER_EVT_CNT_EN adds an 8-bit wrapping debounce event counter.
module switch_conditioner
    import switch_conditioner_pkg::*;
#(
    parameter int WIDTH           = SW_WIDTH,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             overrun,
    input  logic             clear_ovr,
`ifdef SWITCH_CONDITIONER_EVT_CNT_EN
    output logic [7:0]       evt_cnt,
`endif
    output logic [WIDTH-1:0] stable
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] s2;
    logic [WIDTH-1:0] cand_d, cand_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;
    logic [WIDTH-1:0] stable_d, stable_q;
    logic [WIDTH-1:0] out_data_d, out_data_q;
    logic             out_valid_d, out_valid_q;
    logic             overrun_d, overrun_q;
    logic             evt;
    logic             xfer;
    logic             set_ovr;

    switch_conditioner_sync2 #(.WIDTH(WIDTH)) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (data),
        .q     (s2)
    );

    // Any bit change restarts the whole word; the count only runs while the
    // candidate differs from the settled value.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        evt      = 1'b0;
        if (s2 != cand_q) begin
            cand_d = s2;
            cnt_d  = '0;
        end else if (cand_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = cand_q;
                cnt_d    = '0;
                evt      = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else begin
            cnt_d = '0;
        end
    end

    // Newest settled value always wins; an unaccepted one is reported as overrun.
    always_comb begin
        xfer        = out_valid_q && out_ready;
        set_ovr     = evt && out_valid_q && !xfer;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        overrun_d   = overrun_q;
        if (evt) begin
            out_data_d  = stable_d;
            out_valid_d = 1'b1;
        end else if (xfer) begin
            out_valid_d = 1'b0;
        end
        if (set_ovr) begin
            overrun_d = 1'b1;
        end else if (clear_ovr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cand_q      <= '0;
            cnt_q       <= '0;
            stable_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            stable_q    <= stable_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef SWITCH_CONDITIONER_EVT_CNT_EN
    logic [7:0] evt_cnt_d, evt_cnt_q;

    always_comb begin
        evt_cnt_d = evt_cnt_q;
        if (evt) begin
            evt_cnt_d = evt_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            evt_cnt_q <= '0;
        end else begin
            evt_cnt_q <= evt_cnt_d;
        end
    end

    assign evt_cnt = evt_cnt_q;
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign overrun   = overrun_q;
    assign stable    = stable_q;

endmodule

// File: tb/tb_switch_conditioner.sv
// tb/tb_switch_conditioner.sv - self-checking bench for switch_conditioner (DEBOUNCE_CYCLES = 4)
module tb_switch_conditioner;

    localparam int D = 4;

    logic       clock;
    logic       reset;
    logic [3:0] data;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       overrun;
    logic       clear_ovr;
    logic [3:0] stable;
`ifdef SWITCH_CONDITIONER_EVT_CNT_EN
    logic [7:0] evt_cnt;
`endif

    switch_conditioner #(.WIDTH(4), .DEBOUNCE_CYCLES(D)) dut (
        .clock     (clock),
        .reset     (reset),
        .data      (data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .overrun   (overrun),
        .clear_ovr (clear_ovr),
`ifdef SWITCH_CONDITIONER_EVT_CNT_EN
        .evt_cnt   (evt_cnt),
`endif
        .stable    (stable)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model: a value settles once the last D+1 synchronised samples
    // all agree on it and it differs from the current settled value.
    logic [3:0] hq[$];
    logic [3:0] m_stable, m_data;
    logic       m_valid, m_ovr;
    int         m_evt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        hq.delete();
        for (int k = 0; k < D + 3; k++) hq.push_back(4'h0);
        m_stable = 4'h0;
        m_data   = 4'h0;
        m_valid  = 1'b0;
        m_ovr    = 1'b0;
        m_evt    = 0;
    endtask

    task automatic model_edge();
        logic       ev;
        logic       xf;
        logic [3:0] v;
        hq.push_back(data);
        while (hq.size() > D + 3) void'(hq.pop_front());
        v  = hq[0];
        ev = (v != m_stable);
        for (int k = 1; k <= D; k++) if (hq[k] != v) ev = 1'b0;
        xf = m_valid && out_ready;
        if (ev && m_valid && !xf) m_ovr = 1'b1;
        else if (clear_ovr) m_ovr = 1'b0;
        if (ev) begin
            m_stable = v;
            m_data   = v;
            m_valid  = 1'b1;
            m_evt++;
        end else if (xf) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_model();
        check("model stable", 32'(stable), 32'(m_stable));
        check("model out_data", 32'(out_data), 32'(m_data));
        check("model out_valid", 32'(out_valid), 32'(m_valid));
        check("model overrun", 32'(overrun), 32'(m_ovr));
`ifdef SWITCH_CONDITIONER_EVT_CNT_EN
        check("model evt_cnt", 32'(evt_cnt), 32'(m_evt & 255));
`endif
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic steps(input int n);
        for (int k = 0; k < n; k++) step();
    endtask

    // Called just after an edge; reset is pulsed between edges.
    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check("rst out_data", 32'(out_data), 32'h0);
        check("rst out_valid", 32'(out_valid), 32'h0);
        check("rst overrun", 32'(overrun), 32'h0);
        check("rst stable", 32'(stable), 32'h0);
`ifdef SWITCH_CONDITIONER_EVT_CNT_EN
        check("rst evt_cnt", 32'(evt_cnt), 32'h0);
`endif
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] data;
        logic       ready;
        logic [3:0] exp_stable;
        logic       exp_valid;
        logic [3:0] exp_data;
    } vec_t;

    vec_t tbl[9];

    initial begin
        int         n;
        logic       seen;
        int         hold;
        logic [3:0] before_cnt;

        // Clean change 0 -> 5 with ready held high.
        tbl[0] = '{4'h5, 1'b1, 4'h0, 1'b0, 4'h0};
        tbl[1] = '{4'h5, 1'b1, 4'h0, 1'b0, 4'h0};
        tbl[2] = '{4'h5, 1'b1, 4'h0, 1'b0, 4'h0};
        tbl[3] = '{4'h5, 1'b1, 4'h0, 1'b0, 4'h0};
        tbl[4] = '{4'h5, 1'b1, 4'h0, 1'b0, 4'h0};
        tbl[5] = '{4'h5, 1'b1, 4'h0, 1'b0, 4'h0};
        tbl[6] = '{4'h5, 1'b1, 4'h5, 1'b1, 4'h5};
        tbl[7] = '{4'h5, 1'b1, 4'h5, 1'b0, 4'h5};
        tbl[8] = '{4'h5, 1'b1, 4'h5, 1'b0, 4'h5};

        reset     = 1'b1;
        data      = 4'h0;
        out_ready = 1'b0;
        clear_ovr = 1'b0;
        model_reset();
        #12;
        check("init out_valid", 32'(out_valid), 32'h0);
        check("init stable", 32'(stable), 32'h0);
        reset = 1'b0;

        // Reset mid-count, then settle with data steady.
        data = 4'hA;
        steps(3);
        pulse_reset();
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 20) begin
            step();
            n++;
            seen = out_valid;
        end
        check("reset-release event edge", 32'(n), 32'd7);
        check("reset-release out_data", 32'(out_data), 32'hA);
        out_ready = 1'b1;
        step();
        check("reset-release transfer", 32'(out_valid), 32'h0);

        data = 4'h0;
        steps(10);
        check("back to 0 stable", 32'(stable), 32'h0);
        check("back to 0 out_valid", 32'(out_valid), 32'h0);

        // Glitch shorter than the settle window.
`ifdef SWITCH_CONDITIONER_EVT_CNT_EN
        before_cnt = evt_cnt[3:0];
`else
        before_cnt = 4'h0;
`endif
        seen = 1'b0;
        data = 4'h3;
        for (int k = 0; k < 3; k++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        data = 4'h0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        check("glitch no valid", 32'(seen), 32'h0);
        check("glitch stable", 32'(stable), 32'h0);
`ifdef SWITCH_CONDITIONER_EVT_CNT_EN
        check("glitch evt_cnt", 32'(evt_cnt[3:0]), 32'(before_cnt));
`endif

        for (int i = 0; i < 9; i++) begin
            data      = tbl[i].data;
            out_ready = tbl[i].ready;
            step();
            check($sformatf("tbl[%0d] stable", i), 32'(stable), 32'(tbl[i].exp_stable));
            check($sformatf("tbl[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl[%0d] out_data", i), 32'(out_data), 32'(tbl[i].exp_data));
        end

        // Overrun: two settles without the consumer accepting.
        out_ready = 1'b0;
        data = 4'h1;
        steps(8);
        check("ovr first valid", 32'(out_valid), 32'h1);
        check("ovr first overrun", 32'(overrun), 32'h0);
        data = 4'h2;
        steps(8);
        check("ovr out_data", 32'(out_data), 32'h2);
        check("ovr out_valid", 32'(out_valid), 32'h1);
        check("ovr overrun", 32'(overrun), 32'h1);
        clear_ovr = 1'b1;
        step();
        clear_ovr = 1'b0;
        check("ovr cleared", 32'(overrun), 32'h0);
        check("ovr valid kept", 32'(out_valid), 32'h1);

        // Event lands on the same edge as a transfer.
        out_ready = 1'b1;
        step();
        check("sim drain", 32'(out_valid), 32'h0);
        out_ready = 1'b0;
        data = 4'h7;
        steps(8);
        check("sim hold 7", 32'(out_data), 32'h7);
        data = 4'h9;
        steps(6);
        check("sim pre valid", 32'(out_valid), 32'h1);
        check("sim pre data", 32'(out_data), 32'h7);
        out_ready = 1'b1;
        step();
        check("sim valid", 32'(out_valid), 32'h1);
        check("sim data", 32'(out_data), 32'h9);
        check("sim overrun", 32'(overrun), 32'h0);
        step();
        check("sim drained", 32'(out_valid), 32'h0);

`ifdef SWITCH_CONDITIONER_EVT_CNT_EN
        // 256 settled changes wrap the counter back to zero.
        data = 4'h0;
        @(negedge clock);
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            data = (i % 2 == 0) ? 4'hF : 4'h0;
            steps(7);
            if (i == 127) check("wrap half", 32'(evt_cnt), 32'd128);
        end
        check("wrap evt_cnt", 32'(evt_cnt), 32'h0);
`endif

        // Randomised run against the reference model.
        hold = 0;
        for (int i = 0; i < 800; i++) begin
            if (hold == 0) begin
                data = 4'($urandom_range(0, 15));
                hold = $urandom_range(1, 8);
            end
            hold--;
            out_ready = ($urandom_range(0, 3) != 0);
            clear_ovr = ($urandom_range(0, 15) == 0);
            step();
            if (i == 400) pulse_reset();
        end
        clear_ovr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/switch_conditioner.md
Name: switch_conditioner

Overview:
- Input stage sitting directly upstream of the code-detection device.
- Takes raw slide-switch data (SW[3:0]), synchronises it into the clock domain and debounces it as a whole word.
- Presents each newly settled value to the consumer over a valid/ready handshake.
- Flags values lost because the consumer did not accept the previous one in time.

Parameters:
- WIDTH, 4, width of the switch word.
- DEBOUNCE_CYCLES, 500000, consecutive stable cycles required before a new value is accepted (10 ms at 50 MHz). Must be ≥ 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES), derived localparam: debounce counter width.

Ports:
- clock  in  1  system clock (CLOCK50)
- reset  in  1  asynchronous reset, active-high
- data  in  WIDTH  raw switch inputs, asynchronous to clock
- out_data  out  WIDTH  last debounced value presented to the consumer
- out_valid  out  1  out_data holds an unconsumed value
- out_ready  in  1  consumer accepts out_data this cycle
- overrun  out  1  sticky: a settled value replaced an unconsumed one
- clear_ovr  in  1  synchronous clear of overrun
- stable  out  WIDTH  current debounced level, updated regardless of the handshake

Behaviour:
- Reset values: all flops 0, including sync stages, cand, cnt, stable, out_data, out_valid and overrun. Reset is asynchronous; it aborts any debounce in progress and drops any pending value.
- Synchroniser: two flops, s1 <= data, then s2 <= s1. Nothing downstream uses s1.
- Debounce, evaluated every edge:
  - If s2 != cand: cand <= s2 and cnt <= 0, a restart. Any bit change restarts the whole word.
  - Else if cand != stable:
    - If cnt == DEBOUNCE_CYCLES-1: stable <= cand, cnt <= 0, and an internal event fires for this edge.
    - Otherwise cnt <= cnt+1.
  - Else cnt <= 0.
- Latency: a value first captured into s1 at edge t becomes stable, with the event, at edge t+DEBOUNCE_CYCLES+2, provided it does not toggle in between.
- A glitch shorter than DEBOUNCE_CYCLES+1 cycles produces no event. Returning to the current stable value before the count completes produces no event.
- Handshake:
  - A transfer occurs on an edge with out_valid && out_ready.
  - Event with no transfer and out_valid == 0: out_data <= stable_next, out_valid <= 1.
  - Event with no transfer and out_valid == 1: out_data <= stable_next, out_valid stays 1, overrun <= 1. The newest value always wins.
  - Event on the same edge as a transfer: out_data <= new value, out_valid stays 1, no overrun.
  - Transfer with no event: out_valid <= 0. out_data holds its value.
- out_ready while out_valid == 0 is ignored.
- overrun:
  - clear_ovr clears it on the next edge.
  - If clear_ovr and a new overrun condition coincide, set wins.
- cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.

Optional Feature:
- Macro: SWITCH_CONDITIONER_EVT_CNT_EN.
- When defined:
  - Adds output evt_cnt, 8 bits: a count of debounce events since reset.
  - Increments by 1 per event and wraps 255 -> 0. Reset value 0.
  - Counts overrun events too.
- When undefined: the port and logic are absent, and all other behaviour is identical.

Decomposition:
- Shared package:
  - SW_WIDTH = 4.
  - CLK_HZ = 50_000_000.
  - DEBOUNCE_MS = 10.
  - Derived default cycle count.
- Sub-module sync2, a generic 2-flop synchroniser parameterised by width with async active-high reset. It is reused later for KEY inputs.
- The debounce counter and handshake logic stay in switch_conditioner.

Test Plan (DEBOUNCE_CYCLES = 4):
- Reset mid-count:
  - Stimulus: drive data 4'hA, then assert reset 3 edges later.
  - Required: all outputs 0; after release with data steady, out_data = 4'hA and out_valid rises 6 edges after the first sampling edge.
- Clean change with ready held high:
  - Stimulus: data 0 -> 4'h5.
  - Required: out_valid high for exactly 1 cycle after the event, with out_data = 5 and stable = 5.
- Glitch rejection:
  - Stimulus: data 0 -> 4'h3 for 3 cycles, then back to 0.
  - Required: no out_valid; stable stays 0; evt_cnt (if enabled) stays 0.
- Overrun:
  - Stimulus: out_ready = 0; settle 4'h1, then settle 4'h2.
  - Required: out_data = 2, out_valid = 1, overrun = 1.
  - Then: pulse clear_ovr -> overrun = 0, out_valid still 1.
- Simultaneous transfer and event:
  - Stimulus: out_valid = 1 with out_data = 4'h7; the event for 4'h9 lands on the edge where out_ready = 1.
  - Required: out_valid stays 1, out_data = 9, overrun = 0.
- Counter wrap (SWITCH_CONDITIONER_EVT_CNT_EN):
  - Stimulus: 256 alternating settled changes.
  - Required: evt_cnt returns to 0.
